// File: rtl/uart_pixel_loader_if.sv
// uart_pixel_loader_if: UART byte handshake, pixel RAM write port and status
// strobes shared between the frame loader and its surroundings.
// The slave modport is the loader's view; the master modport is the view of
// the UART pair, pixel RAM and LED driver around it.
interface uart_pixel_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  rxReadyIN;
    logic [7:0]            rxDataIN;
    logic                  txReadyIN;
    logic                  txLoadOUT;
    logic [7:0]            txDataOUT;
    logic                  wrEnOUT;
    logic [ADDR_WIDTH-1:0] wrAddrOUT;
    logic [7:0]            wrDataOUT;
    logic                  updateOUT;
    logic                  busyOUT;
    logic                  timeoutOUT;

    modport master (
        output rxReadyIN, rxDataIN, txReadyIN,
        input  txLoadOUT, txDataOUT, wrEnOUT, wrAddrOUT, wrDataOUT,
               updateOUT, busyOUT, timeoutOUT
    );

    modport slave (
        input  rxReadyIN, rxDataIN, txReadyIN,
        output txLoadOUT, txDataOUT, wrEnOUT, wrAddrOUT, wrDataOUT,
               updateOUT, busyOUT, timeoutOUT
    );
endinterface

// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: parses A5-framed host commands from the UART RX byte
// stream, writes WRITE payloads into pixel RAM, requests an LED refresh on
// COMMIT and answers each complete frame with ACK (0x06) or NAK (0x15).
// A frame stalled for TIMEOUT_CYCLES between bytes is abandoned silently.
//
// Optional feature: define UART_LOADER_CHECKSUM_EN to expect a trailing
// 8-bit sum byte (CMD..payload, mod 256); WRITE/COMMIT then ACK only on a
// match and COMMIT refreshes only on a match.
//
// state  | meaning
// IDLE   | waiting for the 0xA5 start byte, everything else ignored
// CMD    | waiting for the command byte
// AH     | waiting for the address high byte
// AL     | waiting for the address low byte
// LEN    | waiting for the payload length
// DATA   | consuming payload bytes (written to RAM for WRITE)
// CSUM   | waiting for the checksum byte (checksum builds only)
// RESP   | holding the response until the transmitter takes it
module uart_pixel_loader #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int ADDR_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES  = 500_000
) (
    input  logic                 clockIN,
    input  logic                 ResetIN,
    uart_pixel_loader_if.slave   bus
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_COMMIT = 8'h02;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    // The counter only has to reach TIMEOUT_CYCLES-2 before it fires.
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Elaboration-time sanity check of the configuration.
    if (TIMEOUT_CYCLES < 2 || CLOCK_FREQUENCY <= 0) begin : g_param_check
        $error("uart_pixel_loader: TIMEOUT_CYCLES must be >= 2 and CLOCK_FREQUENCY > 0");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_AH,
        S_AL,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_is_commit;
    logic [7:0]            r_addr_h;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_remaining;
    logic [7:0]            r_sum;
    logic [7:0]            r_resp;
    logic [CW-1:0]         r_cnt;
    logic                  r_tx_load;
    logic [7:0]            r_tx_data;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_data;
    logic                  r_update;
    logic                  r_timeout;

    logic                  w_rx;
    logic [7:0]            w_byte;
    logic [7:0]            w_sum_next;
    logic [15:0]           w_addr_full;
    logic [ADDR_WIDTH-1:0] w_base;
    logic                  w_in_frame;
    logic                  w_cnt_clear;
    logic                  w_timeout_hit;

    assign w_rx        = bus.rxReadyIN;
    assign w_byte      = bus.rxDataIN;
    assign w_sum_next  = r_sum + w_byte;
    // Address bits above ADDR_WIDTH are dropped, so the payload wraps in RAM.
    assign w_addr_full = {r_addr_h, w_byte};
    assign w_base      = ADDR_WIDTH'(w_addr_full);

    assign w_in_frame    = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_cnt_clear   = w_rx || !w_in_frame;
    // A byte arriving on the terminal cycle wins over the timeout.
    assign w_timeout_hit = w_in_frame && !w_rx && (r_cnt == CW'(TIMEOUT_CYCLES - 2));

    assign bus.txLoadOUT  = r_tx_load;
    assign bus.txDataOUT  = r_tx_data;
    assign bus.wrEnOUT    = r_wr_en;
    assign bus.wrAddrOUT  = r_wr_addr;
    assign bus.wrDataOUT  = r_wr_data;
    assign bus.updateOUT  = r_update;
    assign bus.busyOUT    = (r_state != S_IDLE);
    assign bus.timeoutOUT = r_timeout;

    // Frame FSM, inter-byte timer and all registered outputs.
    always_ff @(posedge clockIN) begin
        if (ResetIN) begin
            r_state     <= S_IDLE;
            r_is_commit <= 1'b0;
            r_addr_h    <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_sum       <= '0;
            r_resp      <= '0;
            r_cnt       <= '0;
            r_tx_load   <= 1'b0;
            r_tx_data   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_update    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_update  <= 1'b0;
            r_timeout <= 1'b0;
            r_tx_load <= 1'b0;
            r_cnt     <= w_cnt_clear ? '0 : r_cnt + 1'b1;

            if (w_timeout_hit) begin
                r_state   <= S_IDLE;
                r_timeout <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rx && w_byte == SYNC_BYTE) begin
                            r_state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (w_rx) begin
                            r_sum <= w_byte;
                            if (w_byte == CMD_WRITE) begin
                                r_is_commit <= 1'b0;
                                r_state     <= S_AH;
                            end else if (w_byte == CMD_COMMIT) begin
                                r_is_commit <= 1'b1;
                                r_state     <= S_AH;
                            end else begin
                                r_resp  <= NAK_BYTE;
                                r_state <= S_RESP;
                            end
                        end
                    end
                    S_AH: begin
                        if (w_rx) begin
                            r_addr_h <= w_byte;
                            r_sum    <= w_sum_next;
                            r_state  <= S_AL;
                        end
                    end
                    S_AL: begin
                        if (w_rx) begin
                            r_addr  <= w_base;
                            r_sum   <= w_sum_next;
                            r_state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (w_rx) begin
                            r_remaining <= w_byte;
                            r_sum       <= w_sum_next;
                            if (w_byte != 8'd0) begin
                                r_state <= S_DATA;
                            end else begin
`ifdef UART_LOADER_CHECKSUM_EN
                                r_state <= S_CSUM;
`else
                                r_resp   <= ACK_BYTE;
                                r_update <= r_is_commit;
                                r_state  <= S_RESP;
`endif
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_rx) begin
                            r_sum       <= w_sum_next;
                            r_remaining <= r_remaining - 8'd1;
                            r_addr      <= r_addr + 1'b1;
                            if (!r_is_commit) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_addr;
                                r_wr_data <= w_byte;
                            end
                            if (r_remaining == 8'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                r_state <= S_CSUM;
`else
                                r_resp   <= ACK_BYTE;
                                r_update <= r_is_commit;
                                r_state  <= S_RESP;
`endif
                            end
                        end
                    end
                    S_CSUM: begin
                        if (w_rx) begin
                            r_resp   <= (w_byte == r_sum) ? ACK_BYTE : NAK_BYTE;
                            r_update <= r_is_commit && (w_byte == r_sum);
                            r_state  <= S_RESP;
                        end
                    end
                    S_RESP: begin
                        // Received bytes are discarded here; leave only after
                        // the load strobe has been on the bus for its cycle.
                        if (r_tx_load) begin
                            r_state <= S_IDLE;
                        end else if (bus.txReadyIN) begin
                            r_tx_load <= 1'b1;
                            r_tx_data <= r_resp;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
